gsr_pur_gen: RTL and testbench
==============================

Name: gsr_pur_gen

Overview:
Global reset-net generator that drives the GSRNET (global set/reset) and PURNET (power-up reset) nets consumed by the I/O primitive models (DDR input cells etc.) in mixed-HDL builds. After power-on reset it holds both nets asserted for a programmable window, then releases them. It also converts a user global-reset request into a clean, SCLK-synchronous GSRNET pulse. All nets are active-low; a primitive resets while GSRNET&PURNET=0.

Parameters:
SYNC_STAGES, 2, flop stages in each synchronizer (legal range ≥2).
PUR_CYCLES, 16, SCLK cycles PURNET stays low after synchronized RSTN release (0 allowed).
GSR_MIN_CYCLES, 4, minimum GSRNET low width in cycles when GSR_STRETCH_EN is defined (≥1).

Ports:
SCLK  in  1  system clock; all outputs are registered on its rising edge.
RSTN  in  1  asynchronous active-low power-on reset.
GSR_REQ_N  in  1  user global-reset request, active-low, asynchronous to SCLK.
GSRNET  out  1  global set/reset net, active-low.
PURNET  out  1  power-up reset net, active-low.
SRN  out  1  combined net = GSRNET & PURNET, registered.
READY  out  1  high when GSRNET=1 and PURNET=1.

Behaviour:
- Clock/reset: single clock SCLK. Reset RSTN is asynchronous and active-low.
- RSTN=0: GSRNET=PURNET=SRN=READY=0 immediately, without a clock edge. Counters=0, state=PWR_UP, synchronizer flops=0.
- RSTN release: passes through a SYNC_STAGES reset synchronizer (async assert, sync deassert).
- States: PWR_UP, RUN, GSR_HOLD.
- PWR_UP:
  - Saturating counter increments each cycle after the synchronized release. Counter width is clog2(PUR_CYCLES+1), minimum 1.
  - With RSTN high before edge 1, PURNET goes 1 on edge SYNC_STAGES+PUR_CYCLES (edge 18 with defaults; edge 2 if PUR_CYCLES=0).
  - On that edge, if synchronized GSR_REQ_N=1: GSRNET goes 1 and state moves to RUN. Otherwise GSRNET stays 0 and state moves to GSR_HOLD.
- GSR_REQ_N path: goes through its own SYNC_STAGES synchronizer. Both assertion and release are synchronous.
- RUN: when the synchronized request is seen low, the next edge sets GSRNET=0 and state=GSR_HOLD. With the request low before edge k, GSRNET is low after edge k+SYNC_STAGES.
- GSR_HOLD: exits to RUN with GSRNET=1 on the edge after the synchronized request returns high (subject to the optional stretch).
- PURNET never reasserts except via RSTN. It stays 1 throughout RUN and GSR_HOLD.
- SRN and READY are registered and update on the same edge as GSRNET/PURNET. All outputs are glitch-free flop outputs.
- Request toggling during GSR_HOLD restarts nothing. Only its synchronized level at the exit decision matters.
- RSTN asserted in any state aborts immediately to the reset values and restarts the full power-up sequence.

Optional Feature:
GSR_STRETCH_EN:
- Defined: a hold counter runs in GSR_HOLD. GSRNET stays low for at least GSR_MIN_CYCLES full cycles even if the request is shorter; longer requests give a GSRNET low width equal to the synchronized request width.
- Undefined: no hold counter; GSRNET low width equals the synchronized request low width (a 1-cycle request gives 1 cycle low).

Decomposition:
- Package gsr_pur_pkg holds:
  - the state enum (PWR_UP, RUN, GSR_HOLD);
  - default constants for SYNC_STAGES, PUR_CYCLES and GSR_MIN_CYCLES;
  - a clog2-based width helper.
- One natural sub-module, sync_chain: an N-stage flop synchronizer with async active-low clear. It is instantiated twice:
  - reset-release mode for RSTN;
  - level mode for GSR_REQ_N.

Test Plan:
1. RSTN low 5 cycles then high, GSR_REQ_N=1 -> all outputs 0 through edge 17; GSRNET=PURNET=SRN=READY=1 at edge 18.
2. In RUN, GSR_REQ_N low 1 cycle before edge k:
   - without macro -> GSRNET low exactly 1 cycle (edge k+2 to k+3);
   - with GSR_STRETCH_EN -> low exactly 4 cycles, high at edge k+6. PURNET stays 1 throughout.
3. In RUN, GSR_REQ_N low 10 cycles -> GSRNET/SRN low 10 cycles starting edge k+2, READY=0 for the same span, PURNET=1.
4. GSR_REQ_N held low across power-up, released before edge 30 -> PURNET=1 at edge 18, GSRNET=0 until edge 32, then READY=1.
5. RSTN driven low mid-RUN between clock edges -> GSRNET/PURNET/SRN/READY=0 in the same timestep; release repeats scenario 1 timing.
6. PUR_CYCLES=0, SYNC_STAGES=3 -> PURNET and GSRNET rise at edge 3 after release.

Source files
------------

// File: rtl/gsr_pur_pkg.sv
// Shared types, default parameter values and counter sizing for the global reset-net generator.
package gsr_pur_pkg;

  typedef enum logic [1:0] {
    PWR_UP   = 2'd0,
    RUN      = 2'd1,
    GSR_HOLD = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int PUR_CYCLES_DEF     = 16;
  localparam int GSR_MIN_CYCLES_DEF = 4;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-stage flop synchronizer with async active-low clear. Tie d_i high for reset-release use,
// or feed an asynchronous level for plain level synchronization.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gsr_pur_gen.sv
// Drives active-low GSRNET/PURNET after power-up and on user global-reset requests.
// Define GSR_STRETCH_EN to enforce a minimum GSRNET low width of GSR_MIN_CYCLES.
module gsr_pur_gen
  import gsr_pur_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int PUR_CYCLES     = PUR_CYCLES_DEF,
  parameter int GSR_MIN_CYCLES = GSR_MIN_CYCLES_DEF
) (
  input  logic SCLK,
  input  logic RSTN,
  input  logic GSR_REQ_N,
  output logic GSRNET,
  output logic PURNET,
  output logic SRN,
  output logic READY
);

  localparam int            PW      = cnt_width(PUR_CYCLES);
  localparam logic [PW-1:0] PUR_MAX = PW'(PUR_CYCLES);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (GSR_MIN_CYCLES < 1) begin : g_bad_min
    $error("GSR_MIN_CYCLES must be at least 1");
  end

  logic rel;
  logic req_act;

  // The FSM state register acts as the last stage of the reset-release synchronizer,
  // so PURNET can rise on edge SYNC_STAGES+PUR_CYCLES.
  sync_chain #(.STAGES(SYNC_STAGES - 1)) u_rst_sync (
    .clk   (SCLK),
    .rst_n (RSTN),
    .d_i   (1'b1),
    .q_o   (rel)
  );

  // Request carried active-high so cleared flops mean "no request" after reset.
  sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (SCLK),
    .rst_n (RSTN),
    .d_i   (~GSR_REQ_N),
    .q_o   (req_act)
  );

  state_e        state_q, state_d;
  logic [PW-1:0] pur_cnt_q, pur_cnt_d;
  logic          gsr_q, gsr_d;
  logic          pur_q, pur_d;
  logic          srn_q, srn_d;
  logic          ready_q, ready_d;
  logic          hold_done;

`ifdef GSR_STRETCH_EN
  localparam int            HW       = cnt_width(GSR_MIN_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(GSR_MIN_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (state_d == GSR_HOLD && state_q != GSR_HOLD) hold_d = '0;
    else if (state_q == GSR_HOLD && hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign hold_done = (hold_q == HOLD_MAX);
`else
  assign hold_done = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    pur_cnt_d = pur_cnt_q;
    gsr_d     = gsr_q;
    pur_d     = pur_q;
    case (state_q)
      PWR_UP: begin
        if (rel) begin
          if (pur_cnt_q == PUR_MAX) begin
            pur_d   = 1'b1;
            gsr_d   = !req_act;
            state_d = req_act ? GSR_HOLD : RUN;
          end else begin
            pur_cnt_d = pur_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (req_act) begin
          gsr_d   = 1'b0;
          state_d = GSR_HOLD;
        end
      end
      GSR_HOLD: begin
        if (!req_act && hold_done) begin
          gsr_d   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = PWR_UP;
    endcase
    srn_d   = gsr_d & pur_d;
    ready_d = gsr_d & pur_d;
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= PWR_UP;
      pur_cnt_q <= '0;
      gsr_q     <= 1'b0;
      pur_q     <= 1'b0;
      srn_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pur_cnt_q <= pur_cnt_d;
      gsr_q     <= gsr_d;
      pur_q     <= pur_d;
      srn_q     <= srn_d;
      ready_q   <= ready_d;
    end
  end

  assign GSRNET = gsr_q;
  assign PURNET = pur_q;
  assign SRN    = srn_q;
  assign READY  = ready_q;

endmodule

// File: tb/tb_gsr_pur_gen.sv
// Directed bench for gsr_pur_gen: segment table for the main timing scenarios plus
// hand-written async-reset and short-power-up (PUR_CYCLES=0, SYNC_STAGES=3) sequences.
module tb_gsr_pur_gen;

  logic SCLK;
  logic RSTN, GSR_REQ_N;
  logic GSRNET, PURNET, SRN, READY;
  logic rstn2, req2_n;
  logic gsr2, pur2, srn2, ready2;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef GSR_STRETCH_EN
  localparam int PULSE_LOW = 4;
`else
  localparam int PULSE_LOW = 1;
`endif

  localparam logic [3:0] ALL0 = 4'b0000;
  localparam logic [3:0] ALL1 = 4'b1111;
  localparam logic [3:0] GSR0 = 4'b0100;

  gsr_pur_gen u_dut (
    .SCLK      (SCLK),
    .RSTN      (RSTN),
    .GSR_REQ_N (GSR_REQ_N),
    .GSRNET    (GSRNET),
    .PURNET    (PURNET),
    .SRN       (SRN),
    .READY     (READY)
  );

  gsr_pur_gen #(.SYNC_STAGES(3), .PUR_CYCLES(0)) u_dut2 (
    .SCLK      (SCLK),
    .RSTN      (rstn2),
    .GSR_REQ_N (req2_n),
    .GSRNET    (gsr2),
    .PURNET    (pur2),
    .SRN       (srn2),
    .READY     (ready2)
  );

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  // One table row: hold these inputs for 'edges' clock edges, expecting
  // {GSRNET,PURNET,SRN,READY} after each of them.
  typedef struct {
    logic       rstn;
    logic       req_n;
    int         edges;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic rstn, input logic req_n);
    RSTN      = rstn;
    GSR_REQ_N = req_n;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got {GSRNET,PURNET,SRN,READY}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
  endtask

  initial begin
    RSTN      = 1'b0;
    GSR_REQ_N = 1'b1;
    rstn2     = 1'b0;
    req2_n    = 1'b1;

    // Scenario 1: power-up with no request
    vecs.push_back('{1'b0, 1'b1, 5,  ALL0, "reset_hold"});
    vecs.push_back('{1'b1, 1'b1, 17, ALL0, "pur_window"});
    vecs.push_back('{1'b1, 1'b1, 1,  ALL1, "pur_release_e18"});
    vecs.push_back('{1'b1, 1'b1, 5,  ALL1, "run_idle"});
    // Scenario 2: one-cycle request
    vecs.push_back('{1'b1, 1'b0, 1,  ALL1, "short_req_ek"});
    vecs.push_back('{1'b1, 1'b1, 1,  ALL1, "short_req_ek1"});
    vecs.push_back('{1'b1, 1'b1, PULSE_LOW, GSR0, "short_req_low"});
    vecs.push_back('{1'b1, 1'b1, 6,  ALL1, "short_req_after"});
    // Scenario 3: ten-cycle request
    vecs.push_back('{1'b1, 1'b0, 2,  ALL1, "long_req_sync"});
    vecs.push_back('{1'b1, 1'b0, 8,  GSR0, "long_req_low_a"});
    vecs.push_back('{1'b1, 1'b1, 2,  GSR0, "long_req_low_b"});
    vecs.push_back('{1'b1, 1'b1, 5,  ALL1, "long_req_after"});
    // Scenario 4: request held across power-up, released before edge 30
    vecs.push_back('{1'b0, 1'b0, 3,  ALL0, "req_reset"});
    vecs.push_back('{1'b1, 1'b0, 17, ALL0, "req_pur_window"});
    vecs.push_back('{1'b1, 1'b0, 1,  GSR0, "req_pur_e18"});
    vecs.push_back('{1'b1, 1'b0, 11, GSR0, "req_hold_e19_29"});
    vecs.push_back('{1'b1, 1'b1, 2,  GSR0, "req_hold_e30_31"});
    vecs.push_back('{1'b1, 1'b1, 4,  ALL1, "req_release_e32"});

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].req_n);
      for (int e = 0; e < vecs[i].edges; e++) begin
        step();
        checkOutput(vecs[i].name, {GSRNET, PURNET, SRN, READY}, vecs[i].exp);
      end
    end

    // Scenario 5: RSTN dropped between edges while in RUN
    @(posedge SCLK);
    #3;
    RSTN = 1'b0;
    #1;
    checkOutput("async_reset", {GSRNET, PURNET, SRN, READY}, ALL0);
    step();
    checkOutput("async_reset_hold", {GSRNET, PURNET, SRN, READY}, ALL0);
    step();
    checkOutput("async_reset_hold", {GSRNET, PURNET, SRN, READY}, ALL0);
    applyStimulus(1'b1, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      step();
      checkOutput($sformatf("repowerup_e%0d", n), {GSRNET, PURNET, SRN, READY},
                  (n < 18) ? ALL0 : ALL1);
    end

    // Scenario 6: PUR_CYCLES=0, SYNC_STAGES=3 instance
    checkOutput("dut2_reset", {gsr2, pur2, srn2, ready2}, ALL0);
    rstn2 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      checkOutput($sformatf("dut2_e%0d", n), {gsr2, pur2, srn2, ready2},
                  (n < 3) ? ALL0 : ALL1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
